dac_channel_scheduler: RTL
==========================

Name: dac_channel_scheduler

Overview:
- Shares the single 28-bit DAC serial command path (DAC_in/go_DAC to the SPI serializer, `trans` back) between up to 8 channel requesters.
- After reset it issues the internal-reference setup command once. It then grants pending channel requests round-robin and builds a write-and-update command for each grant.
- It sits between the per-channel sample producers and the DAC SPI serializer, and replaces the single-channel DAC sequencing logic.

Parameters:
- NUM_CH, 8: number of requesters, legal range 1..8, equal to the DAC address space.
- DATA_W, 12: sample width. Fixed by the command format; any other value is illegal.
- BUSY_TO, 15: cycles to wait for `trans` to rise after go_DAC before declaring a timeout.

Ports:
- clk  in  1  system clock, rising edge.
- reset_Async  in  1  reset, asynchronous, active-high.
- ch_req  in  NUM_CH  per-channel request level, held by the requester until its ch_ack.
- ch_data  in  NUM_CH*12  flattened samples; channel i occupies bits [12i+11:12i].
- ch_ack  out  NUM_CH  one-cycle grant pulse; the sample is captured on this cycle.
- trans  in  1  serializer busy flag.
- DAC_in  out  28  command word {cmd[3:0], addr[3:0], data[11:0], tail[7:0]}.
- go_DAC  out  1  one-cycle start pulse to the serializer.
- init_done  out  1  high once the reference setup command has completed.
- cur_ch  out  3  channel of the last grant.
- err_timeout  out  1  sticky; set when `trans` fails to rise within BUSY_TO cycles.

Behaviour:
- Reset values: state=SETUP, DAC_in=0x8000001 ({8,0,000,01}), go_DAC=0, ch_ack=0, init_done=0, cur_ch=NUM_CH-1, err_timeout=0, rr pointer=NUM_CH-1, timeout counter=0.
- Reset asserted mid-transfer aborts immediately. On release the block re-runs SETUP; no grant is issued before init_done=1.
- All outputs are registered.
- FSM states and transitions:
  - SETUP: DAC_in=0x8000001 -> GO.
  - GO: go_DAC=1 for exactly one cycle; clear the timeout counter -> WAIT_RISE.
  - WAIT_RISE:
    - trans=1 -> WAIT_FALL.
    - Otherwise increment the counter. When the counter reaches BUSY_TO, set err_timeout and go -> WAIT_FALL.
  - WAIT_FALL: trans=0 -> DONE; else stay.
  - DONE: set init_done=1 -> ARB.
  - ARB: choose the first channel with ch_req=1, searching from pointer+1 with wrap modulo NUM_CH.
    - On a grant: register DAC_in={4'd3, {1'b0,ch}, ch_data[ch], 8'd0}, pulse ch_ack[ch], set cur_ch=ch and pointer=ch -> GO.
    - No request: stay in ARB; DAC_in holds its last value.
- DAC_in is stable from the GO cycle until the FSM next returns to ARB.
- go_DAC is asserted exactly one cycle after the grant cycle.
- Minimum spacing between grants: GO + WAIT_RISE (≥1 cycle) + serializer busy time + WAIT_FALL exit + DONE + ARB.
- ch_req is sampled only in ARB.
  - A requester may drop ch_req on its ack cycle.
  - If it keeps ch_req high, it is re-eligible but ranks last in the next round.
- Simultaneous requests: strict round-robin, no starvation. All channels requesting continuously produces grant order p+1, p+2, … wrapping.
- With NUM_CH=1, the same channel is granted whenever ch_req=1.
- Address field bits above the channel index are zero; address 4'hF (broadcast) is never generated.
- `trans` already high on entry to WAIT_RISE is accepted as the rise.
- err_timeout clears only on reset.

Decomposition:
- Package dac_pkg holds:
  - CMD_WRITE_UPDATE=4'd3, CMD_REF_SETUP=4'd8.
  - REF_ON_TAIL=8'd1, DAC_WORD_W=28.
  - The state encoding constants SETUP..ARB.
- Sub-module dac_rr_arbiter(NUM_CH): combinational; takes the req vector and pointer, returns grant_valid and grant_idx. Pointer update stays in the parent.

Test Plan:
- Reset release with the serializer model (trans high 3 cycles after go, for 30 cycles) -> DAC_in=0x8000001, single go_DAC pulse; init_done rises at the DONE cycle, then ARB.
- ch_req[2]=1, ch_data[2]=0xABC after init -> ch_ack[2] one cycle; next cycle go_DAC=1 with DAC_in=0x32ABC00; cur_ch=2.
- All 8 ch_req held high, distinct data -> grants in order 0,1,2,…,7,0; each DAC_in address matches the ack; exactly one go_DAC per grant.
- Serializer never raises trans -> err_timeout=1 after 15 idle cycles in WAIT_RISE; the FSM continues and the next grant is still served.
- reset_Async asserted during WAIT_FALL of a channel write -> outputs go to reset values that same cycle (asynchronous); after release, 0x8000001 is reissued before any grant.
- ch_req[5] raised while channel 1's transfer is in WAIT_FALL, ch_req[1] held high -> next grant goes to channel 5, then channel 1.

Source files
------------

// File: rtl/dac_pkg.sv
// Command encoding and FSM state type shared by the DAC channel scheduler and its bench.
package dac_pkg;

    localparam logic [3:0] CMD_WRITE_UPDATE = 4'd3;
    localparam logic [3:0] CMD_REF_SETUP    = 4'd8;
    localparam logic [7:0] REF_ON_TAIL      = 8'd1;
    localparam int         DAC_WORD_W       = 28;

    localparam logic [DAC_WORD_W-1:0] REF_SETUP_WORD =
        {CMD_REF_SETUP, 4'd0, 12'd0, REF_ON_TAIL};

    typedef enum logic [2:0] {
        SETUP     = 3'd0,
        GO        = 3'd1,
        WAIT_RISE = 3'd2,
        WAIT_FALL = 3'd3,
        DONE      = 3'd4,
        ARB       = 3'd5
    } dac_state_t;

    // Address bit 3 stays zero so broadcast (4'hF) can never be produced.
    function automatic logic [DAC_WORD_W-1:0] write_word(input logic [2:0]  ch,
                                                         input logic [11:0] data);
        return {CMD_WRITE_UPDATE, 1'b0, ch, data, 8'd0};
    endfunction

endpackage

// File: rtl/dac_rr_arbiter.sv
// Combinational round-robin pick: first requester after ptr, wrapping modulo NUM_CH.
module dac_rr_arbiter #(
    parameter int NUM_CH = 8
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [2:0]        ptr,
    output logic              grant_valid,
    output logic [2:0]        grant_idx
);

    logic [7:0] req_pad;

    assign req_pad = 8'(req);

    // Walk the ring backwards so the nearest requester after ptr is the last write.
    always_comb begin
        int j;
        grant_valid = 1'b0;
        grant_idx   = '0;
        j           = 0;
        for (int i = NUM_CH; i >= 1; i--) begin
            j = int'(ptr) + i;
            if (j >= NUM_CH) j = j - NUM_CH;
            if (req_pad[j[2:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = j[2:0];
            end
        end
    end

endmodule

// File: rtl/dac_channel_scheduler.sv
// Shares one DAC serial command path between up to 8 channel requesters,
// issuing the reference setup command once after reset.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   SETUP     | load the internal-reference setup word
//   GO        | fire go_DAC, clear the rise timer
//   WAIT_RISE | wait for the serializer to go busy, time out after BUSY_TO
//   WAIT_FALL | wait for the serializer to finish
//   DONE      | mark init complete
//   ARB       | round-robin grant, capture sample, build write-and-update
module dac_channel_scheduler
    import dac_pkg::*;
#(
    parameter int NUM_CH  = 8,
    parameter int DATA_W  = 12,
    parameter int BUSY_TO = 15
) (
    input  logic                     clk,
    input  logic                     reset_Async,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    output logic [NUM_CH-1:0]        ch_ack,
    input  logic                     trans,
    output logic [DAC_WORD_W-1:0]    DAC_in,
    output logic                     go_DAC,
    output logic                     init_done,
    output logic [2:0]               cur_ch,
    output logic                     err_timeout
);

    localparam int             CNT_W    = $clog2(BUSY_TO + 1);
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(BUSY_TO);
    localparam logic [2:0]     LAST_CH  = 3'(NUM_CH - 1);

    dac_state_t              state, state_n;
    logic [DAC_WORD_W-1:0]   dac_in_n;
    logic                    go_n, init_n, err_n;
    logic [NUM_CH-1:0]       ack_n;
    logic [2:0]              cur_ch_n, ptr, ptr_n;
    logic [CNT_W-1:0]        cnt, cnt_n, cnt_inc;
    logic                    grant_valid;
    logic [2:0]              grant_idx;
    logic [DATA_W-1:0]       sel_data;

    dac_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req         (ch_req),
        .ptr         (ptr),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_comb begin
        sel_data = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (3'(c) == grant_idx) sel_data = ch_data[c*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk or posedge reset_Async) begin
        if (reset_Async) begin
            state       <= SETUP;
            DAC_in      <= REF_SETUP_WORD;
            go_DAC      <= 1'b0;
            ch_ack      <= '0;
            init_done   <= 1'b0;
            cur_ch      <= LAST_CH;
            err_timeout <= 1'b0;
            ptr         <= LAST_CH;
            cnt         <= '0;
        end else begin
            state       <= state_n;
            DAC_in      <= dac_in_n;
            go_DAC      <= go_n;
            ch_ack      <= ack_n;
            init_done   <= init_n;
            cur_ch      <= cur_ch_n;
            err_timeout <= err_n;
            ptr         <= ptr_n;
            cnt         <= cnt_n;
        end
    end

    // All outputs are registered: an action taken in a state shows up one cycle later.
    always_comb begin
        state_n  = state;
        dac_in_n = DAC_in;
        go_n     = 1'b0;
        ack_n    = '0;
        init_n   = init_done;
        cur_ch_n = cur_ch;
        err_n    = err_timeout;
        ptr_n    = ptr;
        cnt_n    = cnt;
        cnt_inc  = cnt + 1'b1;
        case (state)
            SETUP: begin
                dac_in_n = REF_SETUP_WORD;
                state_n  = GO;
            end
            GO: begin
                go_n    = 1'b1;
                cnt_n   = '0;
                state_n = WAIT_RISE;
            end
            WAIT_RISE: begin
                if (trans) begin
                    state_n = WAIT_FALL;
                end else begin
                    cnt_n = cnt_inc;
                    if (cnt_inc == CNT_TC) begin
                        err_n   = 1'b1;
                        state_n = WAIT_FALL;
                    end
                end
            end
            WAIT_FALL: begin
                if (!trans) state_n = DONE;
            end
            DONE: begin
                init_n  = 1'b1;
                state_n = ARB;
            end
            ARB: begin
                if (grant_valid) begin
                    dac_in_n = write_word(grant_idx, sel_data);
                    for (int c = 0; c < NUM_CH; c++) ack_n[c] = (3'(c) == grant_idx);
                    cur_ch_n = grant_idx;
                    ptr_n    = grant_idx;
                    state_n  = GO;
                end
            end
            default: state_n = SETUP;
        endcase
    end

endmodule
